// File: rtl/flxx_alu_issue.sv
// Issue/writeback stage around the combinational flxxalu: EX and WB registers, a regfile and operand resolve.
// Define FLXX_ISSUE_BYPASS_EN for result forwarding; otherwise hazards stall in_ready until writeback.
module flxx_alu_issue #(
    parameter int NREGS = 16,
    parameter int RW    = $clog2(NREGS),
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_opcode,
    input  logic [RW-1:0]   in_rd,
    input  logic [RW-1:0]   in_rs1,
    input  logic [RW-1:0]   in_rs2,
    input  logic            in_useimm,
    input  logic [15:0]     in_imm,
    output logic [3:0]      alu_opcode,
    output logic [XLEN-1:0] alu_reg1,
    output logic [XLEN-1:0] alu_reg2,
    input  logic [XLEN-1:0] alu_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RW-1:0]   out_rd,
    output logic [XLEN-1:0] out_data
);
    logic [XLEN-1:0] regs [NREGS];
    logic            iss_valid;
    logic [RW-1:0]   iss_rd;
    logic            wb_adv;
    logic            ex_adv;
    logic            accept;
    logic            hazard;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] op2;

    assign wb_adv   = !out_valid || out_ready;
    assign ex_adv   = wb_adv;
    assign in_ready = (!iss_valid || ex_adv) && !hazard;
    assign accept   = in_valid && in_ready;

`ifdef FLXX_ISSUE_BYPASS_EN
    // EX result is newer than the WB result, so it wins when both target the same index
    function automatic logic [XLEN-1:0] resolve(
        input logic [RW-1:0]   s,
        input logic [XLEN-1:0] rf_val,
        input logic            iv,
        input logic [RW-1:0]   ird,
        input logic [XLEN-1:0] ares,
        input logic            ov,
        input logic [RW-1:0]   ord,
        input logic [XLEN-1:0] odata
    );
        if (s == '0)
            return '0;
        else if (iv && ird == s)
            return ares;
        else if (ov && ord == s)
            return odata;
        else
            return rf_val;
    endfunction

    assign hazard  = 1'b0;
    assign op1     = resolve(in_rs1, regs[in_rs1], iss_valid, iss_rd, alu_result,
                             out_valid, out_rd, out_data);
    assign rs2_val = resolve(in_rs2, regs[in_rs2], iss_valid, iss_rd, alu_result,
                             out_valid, out_rd, out_data);
`else
    // a source is stale while its producer sits in EX or WB (WB write lands at this edge)
    function automatic logic src_hit(
        input logic [RW-1:0] s,
        input logic          iv,
        input logic [RW-1:0] ird,
        input logic          ov,
        input logic [RW-1:0] ord
    );
        return (s != '0) && ((iv && ird == s) || (ov && ord == s));
    endfunction

    assign hazard  = in_valid &&
                     (src_hit(in_rs1, iss_valid, iss_rd, out_valid, out_rd) ||
                      (!in_useimm && src_hit(in_rs2, iss_valid, iss_rd, out_valid, out_rd)));
    assign op1     = (in_rs1 == '0) ? '0 : regs[in_rs1];
    assign rs2_val = (in_rs2 == '0) ? '0 : regs[in_rs2];
`endif

    assign op2 = in_useimm ? {{(XLEN-16){1'b0}}, in_imm} : rs2_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid  <= 1'b0;
            iss_rd     <= '0;
            alu_opcode <= '0;
            alu_reg1   <= '0;
            alu_reg2   <= '0;
        end else if (accept) begin
            iss_valid  <= 1'b1;
            iss_rd     <= in_rd;
            alu_opcode <= in_opcode;
            alu_reg1   <= op1;
            alu_reg2   <= op2;
        end else if (ex_adv) begin
            iss_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_rd    <= '0;
            out_data  <= '0;
        end else if (iss_valid && wb_adv) begin
            out_valid <= 1'b1;
            out_rd    <= iss_rd;
            out_data  <= alu_result;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (out_valid && out_ready && out_rd != '0) begin
            regs[out_rd] <= out_data;
        end
    end
endmodule

// File: tb/tb_flxx_alu_issue.sv
// Bench for flxx_alu_issue: stand-in ALU, sequential architectural model and directed plus random streams.
module tb_flxx_alu_issue;
    localparam int NREGS = 16;
    localparam int RW    = 4;
    localparam int XLEN  = 32;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_opcode;
    logic [RW-1:0]   in_rd;
    logic [RW-1:0]   in_rs1;
    logic [RW-1:0]   in_rs2;
    logic            in_useimm;
    logic [15:0]     in_imm;
    logic [3:0]      alu_opcode;
    logic [XLEN-1:0] alu_reg1;
    logic [XLEN-1:0] alu_reg2;
    logic [XLEN-1:0] alu_result;
    logic            out_valid;
    logic            out_ready;
    logic [RW-1:0]   out_rd;
    logic [XLEN-1:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;
    int chk_idx  = 0;
    int or_mode;           // 0: hold off, 1: always ready, 2: random
    logic rnd_bit = 1'b1;

    logic [XLEN-1:0]    m_rf [NREGS];
    logic [RW+XLEN-1:0] exp_q [$];
    logic [RW+XLEN-1:0] obs_q [$];

    always #5 clk = ~clk;

    flxx_alu_issue #(.NREGS(NREGS), .RW(RW), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_useimm(in_useimm), .in_imm(in_imm),
        .alu_opcode(alu_opcode), .alu_reg1(alu_reg1), .alu_reg2(alu_reg2),
        .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data)
    );

    function automatic logic [XLEN-1:0] tb_alu(input logic [3:0] op, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SUB:  return a - b;
            OP_ADD:  return a + b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            default: return a;
        endcase
    endfunction

    assign alu_result = tb_alu(alu_opcode, alu_reg1, alu_reg2);
    assign out_ready  = (or_mode == 1) || (or_mode == 2 && rnd_bit);

    always @(negedge clk) rnd_bit = ($urandom_range(0, 3) != 0);

    // transfers are sampled just before the edge that performs them
    always begin
        @(negedge clk);
        #3;
        if (rst)
            obs_q.delete();
        else if (out_valid && out_ready)
            obs_q.push_back({out_rd, out_data});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] op, input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                          input logic [RW-1:0] rs2, input logic ui, input logic [15:0] imm);
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_useimm = ui;
        in_imm    = imm;
    endtask

    // in-order architectural semantics: each accepted op sees all earlier results
    task automatic model_accept();
        logic [XLEN-1:0] a, b, r;
        a = (in_rs1 == 0) ? '0 : m_rf[in_rs1];
        b = in_useimm ? {16'h0, in_imm} : ((in_rs2 == 0) ? '0 : m_rf[in_rs2]);
        r = tb_alu(in_opcode, a, b);
        if (in_rd != 0)
            m_rf[in_rd] = r;
        exp_q.push_back({in_rd, r});
    endtask

    task automatic send(input logic [3:0] op, input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                        input logic [RW-1:0] rs2, input logic ui, input logic [15:0] imm);
        int n;
        @(negedge clk);
        set_in(op, rd, rs1, rs2, ui, imm);
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready)
            check("send_accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        if (in_ready)
            model_accept();
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        idle();
        or_mode = 1;
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 1000) begin
            @(negedge clk);
            #4;
            n++;
        end
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = chk_idx; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s_res%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
        chk_idx = exp_q.size();
    endtask

    initial begin
        int base;
        rst = 1'b1;
        in_valid = 1'b0;
        set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 16'd0);
        or_mode = 1;
        for (int r = 0; r < NREGS; r++) m_rf[r] = '0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_rd", 64'(out_rd), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_alu_opcode", 64'(alu_opcode), 64'd0);
        check("rst_alu_reg1", 64'(alu_reg1), 64'd0);
        check("rst_alu_reg2", 64'(alu_reg2), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);
        check("rel_out_valid", 64'(out_valid), 64'd0);

        // dependent back-to-back ADDs
        @(negedge clk);
        set_in(OP_ADD, 4'd1, 4'd0, 4'd0, 1'b1, 16'd5);
        in_valid = 1'b1;
        #1;
        check("t2_first_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        model_accept();
        @(negedge clk);
        set_in(OP_ADD, 4'd2, 4'd1, 4'd0, 1'b1, 16'd3);
        #1;
        check("t2_alu_opcode", 64'(alu_opcode), 64'(OP_ADD));
        check("t2_alu_reg1", 64'(alu_reg1), 64'd0);
        check("t2_alu_reg2", 64'(alu_reg2), 64'd5);
        check("t2_out_not_yet", 64'(out_valid), 64'd0);
`ifdef FLXX_ISSUE_BYPASS_EN
        check("t2_no_bubble", 64'(in_ready), 64'd1);
        @(posedge clk);
        model_accept();
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("t2_fwd_reg1", 64'(alu_reg1), 64'd5);
`else
        check("t2_stall_ex", 64'(in_ready), 64'd0);
        @(negedge clk);
        #1;
        check("t2_stall_wb", 64'(in_ready), 64'd0);
`endif
        check("t2_lat2_valid", 64'(out_valid), 64'd1);
        check("t2_lat2_rd", 64'(out_rd), 64'd1);
        check("t2_lat2_data", 64'(out_data), 64'd5);
`ifndef FLXX_ISSUE_BYPASS_EN
        @(negedge clk);
        #1;
        check("t2_release", 64'(in_ready), 64'd1);
        @(posedge clk);
        model_accept();
`endif
        drain("t2");
        check("t2_r1", 64'(obs_q[0]), 64'({4'd1, 32'd5}));
        check("t2_r2", 64'(obs_q[1]), 64'({4'd2, 32'd8}));

        // backpressure with three queued ops
        @(negedge clk);
        or_mode = 0;
        set_in(OP_ADD, 4'd8, 4'd0, 4'd0, 1'b1, 16'h11);
        in_valid = 1'b1;
        #1;
        check("t3_acc_a", 64'(in_ready), 64'd1);
        @(posedge clk);
        model_accept();
        @(negedge clk);
        set_in(OP_ADD, 4'd9, 4'd0, 4'd0, 1'b1, 16'h22);
        #1;
        check("t3_acc_b", 64'(in_ready), 64'd1);
        @(posedge clk);
        model_accept();
        @(negedge clk);
        set_in(OP_ADD, 4'd10, 4'd0, 4'd0, 1'b1, 16'h33);
        #1;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            check($sformatf("t3_stall_ready%0d", c), 64'(in_ready), 64'd0);
            check($sformatf("t3_hold_valid%0d", c), 64'(out_valid), 64'd1);
            check($sformatf("t3_hold_rd%0d", c), 64'(out_rd), 64'd8);
            check($sformatf("t3_hold_data%0d", c), 64'(out_data), 64'h11);
            check($sformatf("t3_hold_reg2_%0d", c), 64'(alu_reg2), 64'h22);
        end
        @(negedge clk);
        or_mode = 1;
        #1;
        check("t3_resume", 64'(in_ready), 64'd1);
        @(posedge clk);
        model_accept();
        drain("t3");

        // r0 is never written and always reads zero
        send(OP_ADD, 4'd0, 4'd0, 4'd0, 1'b1, 16'd7);
        send(OP_ADD, 4'd5, 4'd0, 4'd0, 1'b1, 16'd1);
        idle();
        check("t4_reg1_zero", 64'(alu_reg1), 64'd0);
        check("t4_reg2_imm", 64'(alu_reg2), 64'd1);
        drain("t4");
        base = exp_q.size();
        check("t4_r0_result", 64'(obs_q[base-2]), 64'({4'd0, 32'd7}));
        check("t4_r5_result", 64'(obs_q[base-1]), 64'({4'd5, 32'd1}));

        // XOR of a register with itself
        send(OP_ADD, 4'd3, 4'd0, 4'd0, 1'b1, 16'hA5A5);
        send(OP_SLL, 4'd4, 4'd3, 4'd0, 1'b1, 16'd16);
        send(OP_OR,  4'd3, 4'd4, 4'd3, 1'b0, 16'd0);
        send(OP_XOR, 4'd6, 4'd3, 4'd3, 1'b0, 16'd0);
        idle();
        check("t5_opcode", 64'(alu_opcode), 64'(OP_XOR));
        check("t5_reg1", 64'(alu_reg1), 64'hA5A5A5A5);
        check("t5_reg2", 64'(alu_reg2), 64'hA5A5A5A5);
        @(negedge clk);
        #1;
        check("t5_out_rd", 64'(out_rd), 64'd6);
        check("t5_out_data", 64'(out_data), 64'd0);
        drain("t5");

        // immediate operand ignores an in-flight rs2
        send(OP_ADD, 4'd1, 4'd0, 4'd0, 1'b1, 16'd2);
        @(negedge clk);
        set_in(OP_ADD, 4'd7, 4'd0, 4'd1, 1'b1, 16'hFFFF);
        in_valid = 1'b1;
        #1;
        check("t6_no_stall", 64'(in_ready), 64'd1);
        @(posedge clk);
        model_accept();
        idle();
        check("t6_reg2_zext", 64'(alu_reg2), 64'h0000FFFF);
        drain("t6");

        // reset in the middle of a stream
        or_mode = 2;
        for (int k = 0; k < 6; k++)
            send(OP_ADD, 4'($urandom_range(1, 7)), 4'($urandom_range(0, 7)), 4'd0, 1'b1,
                 16'($urandom));
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        chk_idx = 0;
        for (int r = 0; r < NREGS; r++) m_rf[r] = '0;
        #1;
        check("t1_rst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        check("t1_rst_alu_reg1", 64'(alu_reg1), 64'd0);
        check("t1_rst_out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        or_mode = 1;
        #1;
        check("t1_rel_out_valid", 64'(out_valid), 64'd0);
        check("t1_rel_in_ready", 64'(in_ready), 64'd1);
        for (int r = 1; r < NREGS; r++)
            send(OP_ADD, 4'd0, 4'(r), 4'd0, 1'b1, 16'd0);
        drain("t1");
        for (int r = 1; r < NREGS && r <= obs_q.size(); r++)
            check($sformatf("t1_r%0d_zero", r), 64'(obs_q[r-1][XLEN-1:0]), 64'd0);

        // random stream with random backpressure and gaps
        or_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0)
                idle();
            send(4'($urandom_range(0, 6)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                 4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom));
        end
        drain("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
